// File: rtl/tau_pkg.sv
// Shared definitions for the tau processor return-address stack.
package tau_pkg;

   localparam int ADDR_WIDTH = 8;

   // Stack operation decoded from {push, pop}.
   typedef enum logic [1:0] {
      NONE    = 2'b00,
      POP     = 2'b01,
      PUSH    = 2'b10,
      REPLACE = 2'b11
   } stack_op_t;

   function automatic stack_op_t decode_op(input logic push, input logic pop);
      return stack_op_t'({push, pop});
   endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             write_en,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is never reset; entries are only meaningful below the stack pointer.
   always_ff @(posedge clock) begin
      if (write_en) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack: push on call, combinational top-of-stack for return.
module return_stack
   import tau_pkg::*;
#(
   parameter int WIDTH = ADDR_WIDTH,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] push_value,
   output logic [WIDTH-1:0] pop_value,
   output logic [LW-1:0]    level,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   logic [LW-1:0]    sp;
   logic [LW-1:0]    sp_next;
   logic [LW-1:0]    sp_minus_one;
   logic [AW-1:0]    top_idx;
   logic             write_en;
   logic [AW-1:0]    write_addr;
   logic             set_overflow;
   logic             set_underflow;
   logic [WIDTH-1:0] read_data;
   stack_op_t        op;

   assign op           = decode_op(push, pop);
   assign empty        = (sp == '0);
   assign full         = (sp == LW'(DEPTH));
   assign level        = sp;
   assign sp_minus_one = sp - LW'(1);
   // Index of the top entry; garbage when empty, but pop_value masks that case.
   assign top_idx      = sp_minus_one[AW-1:0];
   assign pop_value    = empty ? '0 : read_data;

   stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
      .clock      (clock),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (push_value),
      .read_addr  (top_idx),
      .read_data  (read_data)
   );

   // Next stack pointer, memory write and flag requests for the decoded op.
   always_comb begin
      sp_next       = sp;
      write_en      = 1'b0;
      write_addr    = sp[AW-1:0];
      set_overflow  = 1'b0;
      set_underflow = 1'b0;
      unique case (op)
         PUSH: begin
            if (full) begin
               set_overflow = 1'b1;
            end else begin
               write_en = 1'b1;
               sp_next  = sp + LW'(1);
            end
         end
         POP: begin
            if (empty) set_underflow = 1'b1;
            else       sp_next       = sp_minus_one;
         end
         REPLACE: begin
            write_en = 1'b1;
            if (empty) begin
               // Return with nothing to return to, but the call still lands.
               set_underflow = 1'b1;
               write_addr    = '0;
               sp_next       = LW'(1);
            end else begin
               write_addr = top_idx;
            end
         end
         default: ;
      endcase
      // Writes are suppressed while held in reset or stalled.
      write_en = write_en & enable & reset;
   end

   // Stack pointer and sticky flags; clear wins over a same-cycle set and ignores enable.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (enable) sp <= sp_next;
         if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else if (enable) begin
            if (set_overflow)  overflow  <= 1'b1;
            if (set_underflow) underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack, including a small loadable counter model.
module tb_return_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] push_value = '0;
   logic [WIDTH-1:0] pop_value;
   logic [LW-1:0]    level;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   // Program counter model for the call/return integration steps.
   logic [WIDTH-1:0] pc;
   logic             load = 1'b0;
   logic             count = 1'b0;

   int tests = 0;
   int fails = 0;

   return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .push       (push),
      .pop        (pop),
      .clear      (clear),
      .push_value (push_value),
      .pop_value  (pop_value),
      .level      (level),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clock = ~clock;

   // Loadable counter: load takes pop_value, otherwise counts when enabled.
   always @(posedge clock) begin
      if (!reset)     pc <= '0;
      else if (load)  pc <= pop_value;
      else if (count) pc <= pc + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic en, input logic pu, input logic po,
                        input logic cl, input logic [WIDTH-1:0] v);
      reset = rs; enable = en; push = pu; pop = po; clear = cl; push_value = v;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      idle();
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_level", 32'(level), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_unf", 32'(underflow), 0);
      check("rst_pop_value", 32'(pop_value), 0);

      // Push three, pop three in LIFO order
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10); tick();
      check("push1_top", 32'(pop_value), 32'h10);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20); tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30); tick();
      idle();
      check("push3_level", 32'(level), 3);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check("pop_a", 32'(pop_value), 32'h30); tick();
      check("pop_b", 32'(pop_value), 32'h20); tick();
      check("pop_c", 32'(pop_value), 32'h10); tick();
      idle();
      check("pops_empty", 32'(empty), 1);
      check("pops_flags", 32'({overflow, underflow}), 0);

      // Fill to DEPTH, then overflow
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i)); tick();
      end
      idle();
      check("fill_full", 32'(full), 1);
      check("fill_ovf_clear", 32'(overflow), 0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF); tick(); idle();
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_level", 32'(level), 8);
      check("ovf_top", 32'(pop_value), 32'h08);

      // Replace while full: top swapped, no new overflow after clear
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5); tick(); idle();
      check("full_repl_top", 32'(pop_value), 32'hA5);
      check("full_repl_level", 32'(level), 8);
      check("full_repl_ovf", 32'(overflow), 0);

      // Underflow on empty, then clear
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick(); idle();
      check("unf_flag", 32'(underflow), 1);
      check("unf_level", 32'(level), 0);
      check("unf_pop_value", 32'(pop_value), 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); tick(); idle();
      check("clear_flags", 32'({overflow, underflow}), 0);

      // Tail-call replace
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40); tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
      check("repl_old_top", 32'(pop_value), 32'h40); tick(); idle();
      check("repl_new_top", 32'(pop_value), 32'h55);
      check("repl_level", 32'(level), 1);
      check("repl_unf", 32'(underflow), 0);

      // Push+pop on empty: underflow and push still lands
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
      check("epp_pop_value", 32'(pop_value), 0); tick(); idle();
      check("epp_unf", 32'(underflow), 1);
      check("epp_level", 32'(level), 1);
      check("epp_top", 32'(pop_value), 32'h77);

      // Clear works while enable is low; enable low blocks push
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99); tick();
      check("clear_no_en", 32'(underflow), 0);
      check("noen_level", 32'(level), 1);
      check("noen_top", 32'(pop_value), 32'h77);

      // Push 0x12, stalled push, then reset during a push
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h34); tick();
      check("stall_level", 32'(level), 1);
      check("stall_top", 32'(pop_value), 32'h12);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h56); tick();
      check("rstpush_level", 32'(level), 0);
      check("rstpush_empty", 32'(empty), 1);
      check("rstpush_flags", 32'({overflow, underflow}), 0);

      // Call/return with the counter: pc counts to 5, call pushes pc+1
      do_reset();
      count = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("pc_pre_call", 32'(pc), 5);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pc + 8'd1); tick(); idle();
      tick(); tick();
      check("pc_in_callee", 32'(pc), 8);
      count = 1'b0;
      load = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check("ret_pop_value", 32'(pop_value), 32'h06);
      check("ret_level_before", 32'(level), 1);
      tick();
      load = 1'b0;
      idle();
      check("ret_pc", 32'(pc), 32'h06);
      check("ret_level_after", 32'(level), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the tau processor. It saves the program counter on a call and hands it back on a return. On a call, the current `counter_value` of the loadable program counter is pushed. On a return, the top entry is presented combinationally on `pop_value`, so the program counter can take it as `load_value` in the same cycle that `pop` is asserted. The stack is the producer side of the counter's load interface: the counter consumes addresses, this block stores and supplies them.

## Interface
- `WIDTH`, default 8: address width; must match the program counter `WIDTH`.
- `DEPTH`, default 8: number of entries, power of two, at least 2.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `enable`  in  1  global advance; when low, no state changes.
- `push`  in  1  push `push_value` (a call).
- `pop`  in  1  pop the top entry (a return).
- `clear`  in  1  clears the sticky error flags only.
- `push_value`  in  WIDTH  address to save, normally `counter_value + 1`.
- `pop_value`  out  WIDTH  current top entry, combinational; 0 when the stack is empty.
- `level`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `level == 0`.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky; set on a push while full.
- `underflow`  out  1  sticky; set on a pop while empty.

## Operation
- Storage: DEPTH×WIDTH register array plus a stack pointer `sp` (equal to `level`). The top entry is `mem[sp-1]`.
- All actions below require `enable` high. With `enable` low, `sp`, memory and the flags hold, and `pop_value` still reflects the top entry.
- Push only, not full: `mem[sp] <= push_value`, `sp <= sp+1`.
- Push only, full: push is dropped; `sp` and memory unchanged; `overflow <= 1`.
- Pop only, not empty: `sp <= sp-1`. The memory entry is not cleared.
- Pop only, empty: `sp` stays 0; `underflow <= 1`; `pop_value` reads 0.
- Push and pop together, not empty: replace the top (tail-call behaviour). `mem[sp-1] <= push_value`, `sp` unchanged, `pop_value` shows the old top this cycle. This applies when full as well; no overflow is flagged.
- Push and pop together, empty: `underflow <= 1`, push proceeds (`mem[0] <= push_value`, `sp <= 1`), `pop_value` is 0.
- `clear` clears `overflow` and `underflow`. It has priority over a set in the same cycle and works regardless of `enable`.
- Arithmetic: `sp` is an unsigned $clog2(DEPTH)+1-bit value and never wraps. Indices use the low $clog2(DEPTH) bits.

## Timing
- Reset (`reset` low at an edge): `sp = 0`, `overflow = 0`, `underflow = 0`. Reset overrides all other inputs, including during a push/pop sequence. Memory is not reset.
- Outputs after reset: `pop_value = 0`, `level = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `underflow = 0`.
- `pop_value` has zero latency from `sp`/memory: it is valid in the cycle that `pop` is asserted, so the program counter loads it at the same edge that `sp` decrements.
- A pushed value is visible on `pop_value` in the cycle after the push edge.
- `level`, `empty` and `full` are derived from `sp` and update one edge after the request.
- Flags become 1 at the edge following the offending request.

## Structure
- Shared package `tau_pkg`: `ADDR_WIDTH` constant (default for `WIDTH`), plus a `stack_op_t` enum (`NONE`, `PUSH`, `POP`, `REPLACE`) decoded from `{push, pop}`.
- One sub-module is natural: `stack_regfile`. It is a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
- The top level holds `sp`, the flags and the op decode.

## Test plan
- Reset, then push 0x10, 0x20, 0x30 -> `level = 3`; `pop_value` is 0x30, then 0x20, then 0x10 on successive pops; `empty = 1` afterwards, no flags set.
- Fill with DEPTH=8 pushes of 0x01..0x08, then push 0xFF -> `full = 1`, `overflow = 1`, `level = 8`, `pop_value = 0x08`.
- Pop on an empty stack -> `underflow = 1`, `level = 0`, `pop_value = 0`. Then `clear` -> both flags 0 at the next edge.
- Push 0x40, then push and pop together with `push_value` 0x55 -> `level = 1`, `pop_value` is 0x40 in that cycle and 0x55 in the next.
- Push 0x12, then assert push with `enable = 0` -> no change. Then assert `reset` low while pushing -> `level = 0`, `empty = 1`, flags 0.
- Integration with `counter_loadable`: push `counter_value + 1` = 0x06 on a call; on the return cycle assert `pop` and `load` together -> counter becomes 0x06 and `level` decrements at the same edge.
